spi_frame_assembler: RTL

Parametrised receive-side frame assembler on the SPI slave path, between the byte-level SPI slave and the display/register logic. Collects `NUM_BYTES` consecutive received bytes within one slave-select window into a frame and presents the low `OUT_W` bits as a held data word with a one-cycle valid strobe. Frames are aligned to the falling edge of `ss_n`. A frame cut short by `ss_n` deassertion raises an error pulse and increments a saturating error counter.

---
 rtl/spi_frame_assembler_if.sv | 24 ++
 rtl/spi_frame_assembler.sv | 118 +++++++++++
 2 files changed

// File: rtl/spi_frame_assembler_if.sv
// Byte-in / frame-out bundle between the SPI slave byte layer and the frame assembler.
// The master side drives received bytes; the slave side (assembler) returns frames and status.
interface spi_frame_assembler_if #(
  parameter int OUT_W = 14
);
  logic [7:0]       rx_data;
  logic             done;
  logic             ss_n;
  logic [OUT_W-1:0] frame_data;
  logic             frame_valid;
  logic             frame_err;
  logic [7:0]       err_cnt;
  logic [2:0]       byte_idx;

  modport master (
    output rx_data, done, ss_n,
    input  frame_data, frame_valid, frame_err, err_cnt, byte_idx
  );

  modport slave (
    input  rx_data, done, ss_n,
    output frame_data, frame_valid, frame_err, err_cnt, byte_idx
  );
endinterface

// File: rtl/spi_frame_assembler.sv
// Assembles NUM_BYTES SPI bytes per slave-select window into a held OUT_W-bit frame word.
// Byte order is MSB-first unless SPI_FRAME_LSB_FIRST_EN is defined (then LSB-first).
module spi_frame_assembler #(
  parameter int NUM_BYTES = 2,
  parameter int OUT_W     = 14
) (
  input logic                 clk,
  input logic                 reset,
  spi_frame_assembler_if.slave bus
);

  localparam int          SW   = NUM_BYTES * 8;
  localparam logic [2:0]  LAST = 3'(NUM_BYTES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic             ss_n_q;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [SW-1:0]    shreg_q, shreg_d;
  logic [OUT_W-1:0] frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [SW-1:0]    asm_w;
  logic             sel_edge, rel_edge;

  // Byte slot inside the frame register for the byte with index idx.
  function automatic logic [2:0] byte_pos(input logic [2:0] idx);
`ifdef SPI_FRAME_LSB_FIRST_EN
    return idx;
`else
    return LAST - idx;
`endif
  endfunction

  assign sel_edge = ~bus.ss_n & ss_n_q;
  assign rel_edge = bus.ss_n & ~ss_n_q;

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shreg_d       = shreg_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    asm_w         = shreg_q;
    case (state_q)
      IDLE: begin
        if (sel_edge) begin
          byte_idx_d = 3'd0;
          shreg_d    = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (sel_edge) begin
          byte_idx_d = 3'd0;
          shreg_d    = '0;
        end else begin
          if (bus.done) begin
            asm_w = shreg_q | (SW'(bus.rx_data) << {byte_pos(byte_idx_q), 3'b000});
            if (byte_idx_q == LAST) begin
              frame_data_d  = OUT_W'(asm_w);
              frame_valid_d = 1'b1;
              byte_idx_d    = 3'd0;
              shreg_d       = '0;
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
              shreg_d    = asm_w;
            end
          end
          // Abort decision uses the index after any same-cycle byte has been counted.
          if (rel_edge) begin
            state_d = IDLE;
            if (byte_idx_d != 3'd0) begin
              frame_err_d = 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
              byte_idx_d = 3'd0;
              shreg_d    = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ss_n_q        <= 1'b1;
      byte_idx_q    <= 3'd0;
      shreg_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      ss_n_q        <= bus.ss_n;
      byte_idx_q    <= byte_idx_d;
      shreg_q       <= shreg_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.byte_idx    = byte_idx_q;

endmodule
